id_ex_control: RTL and testbench

- ID-stage main control plus ID/EX pipeline register for the 5-stage core.
- Decodes the 32-bit instruction into ALUOp/funct3/funct7, the operand-select and memory/writeback controls, and the immediate. These are registered into EX, where the ALU controller turns ALUOp/funct into EXE_CMD.
- Also detects load-use hazards and inserts bubbles, and applies flush and downstream hold.

---
 rtl/id_ex_control.sv | 194 +++++++++++++++++++
 tb/tb_id_ex_control.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_control.sv
// ID-stage main decoder plus the ID/EX pipeline register.
// Handles load-use bubble insertion, flush, downstream hold and a
// saturating count of load-use stall cycles.
module id_ex_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [31:0]      id_instr_i,
  input  logic             flush_i,
  input  logic             ex_hold_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [1:0]       ex_alu_op_o,
  output logic [2:0]       ex_funct3_o,
  output logic [6:0]       ex_funct7_o,
  output logic             ex_alu_src_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             ex_mem_to_reg_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [31:0]      ex_imm_o,
  output logic             ex_illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } ex_t;

  ex_t             dec, ex_d, ex_q;
  logic            use_rs1, use_rs2, ill, hazard;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign opc = id_instr_i[6:0];
  assign f3  = id_instr_i[14:12];
  assign f7  = id_instr_i[31:25];

  // Main decode: opcode -> control fields, immediate and source-use flags.
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    ill     = 1'b0;
    unique case (opc)
      OP_R: begin
        dec.alu_op    = 2'b00;
        dec.funct3    = f3;
        dec.funct7    = f7;
        dec.reg_write = 1'b1;
        dec.rs1       = id_instr_i[19:15];
        dec.rs2       = id_instr_i[24:20];
        dec.rd        = id_instr_i[11:7];
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        if (f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
        if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
      end
      OP_IMM: begin
        dec.alu_op    = 2'b00;
        dec.funct3    = f3;
        // Only shifts carry a real funct7; otherwise imm bits would alias SUB/SRA.
        dec.funct7    = (f3 == 3'b001 || f3 == 3'b101) ? f7 : 7'b0000000;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.rs1       = id_instr_i[19:15];
        dec.rd        = id_instr_i[11:7];
        dec.imm       = {{20{id_instr_i[31]}}, id_instr_i[31:20]};
        use_rs1       = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_op     = 2'b01;
        dec.funct3     = f3;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.rs1        = id_instr_i[19:15];
        dec.rd         = id_instr_i[11:7];
        dec.imm        = {{20{id_instr_i[31]}}, id_instr_i[31:20]};
        use_rs1        = 1'b1;
      end
      OP_STORE: begin
        dec.alu_op    = 2'b01;
        dec.funct3    = f3;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.rs1       = id_instr_i[19:15];
        dec.rs2       = id_instr_i[24:20];
        dec.imm       = {{20{id_instr_i[31]}}, id_instr_i[31:25], id_instr_i[11:7]};
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_LUI: begin
        dec.alu_op    = 2'b10;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.rd        = id_instr_i[11:7];
        dec.imm       = {id_instr_i[31:12], 12'b0};
      end
      default: ill = 1'b1;
    endcase
    // LUI has no funct3 field (those bits are immediate), so it is exempt.
    if (opc != OP_LUI && f3 == 3'b011) ill = 1'b1;
    dec.valid   = 1'b1;
    dec.illegal = ill;
    if (ill) begin
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
    end
  end

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid_i &&
             ((use_rs1 && id_instr_i[19:15] == ex_q.rd) ||
              (use_rs2 && id_instr_i[24:20] == ex_q.rd));
  end

  assign stall_o = ex_hold_i | (hazard & ~flush_i);

  // Next ID/EX contents and stall counter: flush > hold > hazard > load.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (ex_hold_i) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (id_valid_i) begin
      ex_d = dec;
    end else begin
      ex_d = '0;
    end
  end

  // ID/EX register and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_funct3_o     = ex_q.funct3;
  assign ex_funct7_o     = ex_q.funct7;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign ex_rs1_o        = ex_q.rs1;
  assign ex_rs2_o        = ex_q.rs2;
  assign ex_rd_o         = ex_q.rd;
  assign ex_imm_o        = ex_q.imm;
  assign ex_illegal_o    = ex_q.illegal;
  assign stall_cnt_o     = cnt_q;

endmodule

// File: tb/tb_id_ex_control.sv
// Directed bench for id_ex_control: decode, load-use bubbles, flush/hold,
// illegal encodings and counter saturation (second instance with CNT_W=2).
module tb_id_ex_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        flush, hold;

  logic        stall, ex_valid, alu_src, reg_write, mem_read, mem_write, mem_to_reg, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [15:0] cnt;

  logic        stall2, v2, as2, rw2, mr2, mw2, m2r2, il2;
  logic [1:0]  op2;
  logic [2:0]  f32;
  logic [6:0]  f72;
  logic [4:0]  r12, r22, rd2;
  logic [31:0] im2;
  logic [1:0]  cnt2;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] ADDI_M1  = 32'hFFF10093; // addi x1,x2,-1
  localparam logic [31:0] SRAI     = 32'h40315093; // srai x1,x2,3
  localparam logic [31:0] LW_X5    = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] ADD_5_7  = 32'h00728333; // add x6,x5,x7
  localparam logic [31:0] LW_X0    = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] ADD_0_7  = 32'h00700333; // add x6,x0,x7
  localparam logic [31:0] SW       = 32'h0050A223; // sw x5,4(x1)
  localparam logic [31:0] LUI      = 32'h123451B7; // lui x3,0x12345
  localparam logic [31:0] JAL      = 32'h0000006F;
  localparam logic [31:0] MUL      = 32'h023100B3; // funct7=0000001

  id_ex_control u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_instr_i(id_instr),
    .flush_i(flush), .ex_hold_i(hold), .stall_o(stall), .ex_valid_o(ex_valid),
    .ex_alu_op_o(alu_op), .ex_funct3_o(funct3), .ex_funct7_o(funct7),
    .ex_alu_src_o(alu_src), .ex_reg_write_o(reg_write), .ex_mem_read_o(mem_read),
    .ex_mem_write_o(mem_write), .ex_mem_to_reg_o(mem_to_reg), .ex_rs1_o(rs1),
    .ex_rs2_o(rs2), .ex_rd_o(rd), .ex_imm_o(imm), .ex_illegal_o(illegal),
    .stall_cnt_o(cnt)
  );

  id_ex_control #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_instr_i(id_instr),
    .flush_i(flush), .ex_hold_i(hold), .stall_o(stall2), .ex_valid_o(v2),
    .ex_alu_op_o(op2), .ex_funct3_o(f32), .ex_funct7_o(f72),
    .ex_alu_src_o(as2), .ex_reg_write_o(rw2), .ex_mem_read_o(mr2),
    .ex_mem_write_o(mw2), .ex_mem_to_reg_o(m2r2), .ex_rs1_o(r12),
    .ex_rs2_o(r22), .ex_rd_o(rd2), .ex_imm_o(im2), .ex_illegal_o(il2),
    .stall_cnt_o(cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; flush = 1'b0; hold = 1'b0;
    tick(); tick();
    check("rst_valid", ex_valid, 0);
    check("rst_cnt", cnt, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;

    // ADDI negative immediate must not look like SUB
    id_valid = 1'b1; id_instr = ADDI_M1; tick();
    check("addi_valid", ex_valid, 1);
    check("addi_aluop", alu_op, 2'b00);
    check("addi_f3", funct3, 3'b000);
    check("addi_f7", funct7, 7'b0000000);
    check("addi_imm", imm, 32'hFFFFFFFF);
    check("addi_src", alu_src, 1);
    check("addi_rd", rd, 1);
    check("addi_rs1", rs1, 2);
    check("addi_rw", reg_write, 1);

    id_instr = SRAI; tick();
    check("srai_f7", funct7, 7'b0100000);
    check("srai_f3", funct3, 3'b101);
    check("srai_imm", imm, 32'h00000403);

    // async reset while EX holds a valid instruction
    rst_n = 1'b0; #1;
    check("arst_valid", ex_valid, 0);
    check("arst_imm", imm, 0);
    check("arst_f7", funct7, 0);
    check("arst_stall", stall, 0);
    rst_n = 1'b1;

    // load-use: one bubble, one counted stall
    id_instr = LW_X5; tick();
    check("lw_mr", mem_read, 1);
    check("lw_m2r", mem_to_reg, 1);
    check("lw_aluop", alu_op, 2'b01);
    check("lw_rd", rd, 5);
    id_instr = ADD_5_7; #1;
    check("lu_stall", stall, 1);
    tick();
    check("lu_bubble", ex_valid, 0);
    check("lu_bub_rd", rd, 0);
    check("lu_cnt", cnt, 1);
    check("lu_stall_off", stall, 0);
    tick();
    check("add_valid", ex_valid, 1);
    check("add_rd", rd, 6);
    check("add_rs1", rs1, 5);
    check("add_rs2", rs2, 7);
    check("add_src", alu_src, 0);

    // x0 destination never stalls
    id_instr = LW_X0; tick();
    id_instr = ADD_0_7; #1;
    check("x0_stall", stall, 0);
    tick();
    check("x0_add_valid", ex_valid, 1);
    check("x0_add_rd", rd, 6);
    check("x0_cnt", cnt, 1);

    // store then LUI
    id_instr = SW; tick();
    check("sw_aluop", alu_op, 2'b01);
    check("sw_imm", imm, 32'h00000004);
    check("sw_rd", rd, 0);
    check("sw_mw", mem_write, 1);
    check("sw_rw", reg_write, 0);
    check("sw_rs2", rs2, 5);
    id_instr = LUI; tick();
    check("lui_aluop", alu_op, 2'b10);
    check("lui_imm", imm, 32'h12345000);
    check("lui_rd", rd, 3);

    // flush beats a pending hazard
    id_instr = LW_X5; tick();
    id_instr = ADD_5_7; flush = 1'b1; #1;
    check("fl_stall", stall, 0);
    tick();
    flush = 1'b0;
    check("fl_bubble", ex_valid, 0);
    check("fl_cnt", cnt, 1);
    tick();
    check("fl_add_rd", rd, 6);

    // hold freezes EX for 3 cycles
    id_instr = LUI; hold = 1'b1; #1;
    check("hold_stall", stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_rd", rd, 6);
      check("hold_stall_n", stall, 1);
    end
    hold = 1'b0; tick();
    check("hold_rel_rd", rd, 3);

    // flush with hold
    id_instr = ADDI_M1; flush = 1'b1; hold = 1'b1; tick();
    check("flhold_valid", ex_valid, 0);
    check("flhold_imm", imm, 0);
    flush = 1'b0; hold = 1'b0;

    // illegal encodings
    id_instr = JAL; tick();
    check("jal_valid", ex_valid, 1);
    check("jal_ill", illegal, 1);
    check("jal_rw", reg_write, 0);
    id_instr = MUL; tick();
    check("mul_valid", ex_valid, 1);
    check("mul_ill", illegal, 1);
    check("mul_rw", reg_write, 0);
    id_instr = ADDI_M1; tick();
    check("addi_legal", illegal, 0);

    // no real instruction in ID -> bubble
    id_valid = 1'b0; tick();
    check("idle_valid", ex_valid, 0);
    check("idle_rd", rd, 0);
    id_valid = 1'b1;

    // five more hazards: wide counter 6, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      id_instr = LW_X5; tick();
      id_instr = ADD_5_7; tick();
      tick();
    end
    check("cnt_total", cnt, 6);
    check("cnt_sat", cnt2, 3);
    check("add_after_loop", rd, 6);

    // reset mid-stall, then normal load
    id_instr = LW_X5; tick();
    id_instr = ADD_5_7; #1;
    check("ms_stall", stall, 1);
    rst_n = 1'b0; #1;
    check("ms_valid", ex_valid, 0);
    check("ms_stall_rst", stall, 0);
    check("ms_cnt", cnt, 0);
    check("ms_cnt2", cnt2, 0);
    rst_n = 1'b1;
    tick();
    check("ms_load_valid", ex_valid, 1);
    check("ms_load_rd", rd, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
